tile_raster_engine: RTL and testbench

//  Parametrised successor of the fixed 32x32 tile renderer. Accepts one triangle's setup per start/ready handshake,

---
 rtl/tile_raster_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_tile_raster_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_raster_engine.sv
// +----------------------------------------------------------------------------+
// | Module      : tile_raster_engine                                           |
// | Description : Tile rasteriser with incremental edge/Z walk, 3-stage depth  |
// |               test pipeline and tile clear. Optional macro TRE_PIXCOUNT_EN |
// |               adds a pix_count output counting colour writes per job.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tile_raster_engine #(
  parameter int TW_LOG2 = 5,
  parameter int TH_LOG2 = 5,
  parameter int AW      = 19,
  parameter int BW      = 24,
  parameter int WW      = 32,
  parameter int ZW      = 18,
  parameter int CW      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       ready,
  input  logic [AW-1:0]              A01_in,
  input  logic [AW-1:0]              A12_in,
  input  logic [AW-1:0]              A20_in,
  input  logic [BW-1:0]              B01_in,
  input  logic [BW-1:0]              B12_in,
  input  logic [BW-1:0]              B20_in,
  input  logic [WW-1:0]              w0_in,
  input  logic [WW-1:0]              w1_in,
  input  logic [WW-1:0]              w2_in,
  input  logic [ZW-1:0]              dzdx_in,
  input  logic [ZW-1:0]              dzdy_in,
  input  logic [ZW-1:0]              zC_in,
  input  logic [CW-1:0]              color_in,
  input  logic                       clear_in,
  input  logic [1:0]                 depth_func,
  output logic [TW_LOG2-1:0]         X,
  output logic [TH_LOG2-1:0]         Y,
  output logic                       wren,
  output logic [CW-1:0]              color_out,
`ifdef TRE_PIXCOUNT_EN
  output logic [TW_LOG2+TH_LOG2:0]   pix_count,
`endif
  output logic                       done
);

  localparam int ADDR_W = TW_LOG2 + TH_LOG2;
  localparam int NPIX   = 1 << ADDR_W;
  localparam logic [TW_LOG2-1:0] X_LAST = '1;
  localparam logic [TH_LOG2-1:0] Y_LAST = '1;
  localparam logic [TW_LOG2-1:0] X_ONE  = 1;
  localparam logic [TH_LOG2-1:0] Y_ONE  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WALK  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_q;

  // Job setup latched on accept
  logic [AW-1:0]      a01_q, a12_q, a20_q;
  logic [BW-1:0]      b01_q, b12_q, b20_q;
  logic [ZW-1:0]      dzdx_q, dzdy_q, zc_q;
  logic [CW-1:0]      color_q;
  logic               clear_q;
  logic [1:0]         func_q;

  // Walker state
  logic [TW_LOG2-1:0] x_q;
  logic [TH_LOG2-1:0] y_q;
  logic [WW-1:0]      w0_q, w1_q, w2_q;
  logic [WW-1:0]      rb0_q, rb1_q, rb2_q;
  logic [ZW-1:0]      z_q, rowz_q;

  // Pipeline stages
  logic               v1_q, in1_q, v2_q, in2_q;
  logic [ADDR_W-1:0]  addr1_q, addr2_q;
  logic [ZW-1:0]      z1_q, z2_q, zbuf_q;

  logic               ready_q, wren_q, done_q;
  logic [TW_LOG2-1:0] x_out_q;
  logic [TH_LOG2-1:0] y_out_q;
  logic [CW-1:0]      color_out_q;

  logic [ZW-1:0]      depth_mem_q [NPIX];

  logic [WW-1:0]      a01_ext, a12_ext, a20_ext;
  logic [WW-1:0]      b01_ext, b12_ext, b20_ext;
  logic               row_end_d, last_pix_d, cover_d, pass_d, wren_d;
  logic [ZW-1:0]      z_issue_d;

  assign a01_ext = {{(WW-AW){a01_q[AW-1]}}, a01_q};
  assign a12_ext = {{(WW-AW){a12_q[AW-1]}}, a12_q};
  assign a20_ext = {{(WW-AW){a20_q[AW-1]}}, a20_q};
  assign b01_ext = {{(WW-BW){b01_q[BW-1]}}, b01_q};
  assign b12_ext = {{(WW-BW){b12_q[BW-1]}}, b12_q};
  assign b20_ext = {{(WW-BW){b20_q[BW-1]}}, b20_q};

  assign row_end_d  = (x_q == X_LAST);
  assign last_pix_d = row_end_d && (y_q == Y_LAST);
  // A clear job covers every pixel and writes the clear depth
  assign cover_d    = clear_q | (~w0_q[WW-1] & ~w1_q[WW-1] & ~w2_q[WW-1]);
  assign z_issue_d  = clear_q ? zc_q : z_q;

  always_comb begin
    pass_d = 1'b0;
    case (func_q)
      2'b00:   pass_d = (z2_q <  zbuf_q);
      2'b01:   pass_d = (z2_q <= zbuf_q);
      2'b10:   pass_d = 1'b1;
      default: pass_d = 1'b0;
    endcase
  end

  assign wren_d = v2_q & in2_q & (clear_q | pass_d);

  always_ff @(posedge clk) begin
    if (v1_q) zbuf_q <= depth_mem_q[addr1_q];
    if (wren_d && !rst) depth_mem_q[addr2_q] <= z2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      wren_q      <= 1'b0;
      done_q      <= 1'b0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      color_out_q <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
`ifdef TRE_PIXCOUNT_EN
      pix_count   <= '0;
`endif
    end else begin
      done_q  <= 1'b0;
      wren_q  <= wren_d;
      v1_q    <= 1'b0;
      v2_q    <= v1_q;
      addr2_q <= addr1_q;
      in2_q   <= in1_q;
      z2_q    <= z1_q;
      if (v2_q) begin
        x_out_q     <= addr2_q[TW_LOG2-1:0];
        y_out_q     <= addr2_q[ADDR_W-1:TW_LOG2];
        color_out_q <= color_q;
      end
`ifdef TRE_PIXCOUNT_EN
      if (wren_d) pix_count <= pix_count + 1'b1;
`endif
      case (state_q)
        ST_IDLE: begin
          if (start && ready_q) begin
            a01_q   <= A01_in;  a12_q <= A12_in;  a20_q <= A20_in;
            b01_q   <= B01_in;  b12_q <= B12_in;  b20_q <= B20_in;
            dzdx_q  <= dzdx_in; dzdy_q <= dzdy_in; zc_q <= zC_in;
            color_q <= color_in;
            clear_q <= clear_in;
            func_q  <= depth_func;
            x_q     <= '0;
            y_q     <= '0;
            w0_q    <= w0_in;   w1_q  <= w1_in;   w2_q  <= w2_in;
            rb0_q   <= w0_in;   rb1_q <= w1_in;   rb2_q <= w2_in;
            z_q     <= zC_in;
            rowz_q  <= zC_in;
            ready_q <= 1'b0;
            state_q <= ST_WALK;
`ifdef TRE_PIXCOUNT_EN
            pix_count <= '0;
`endif
          end
        end
        ST_WALK: begin
          v1_q    <= 1'b1;
          addr1_q <= {y_q, x_q};
          in1_q   <= cover_d;
          z1_q    <= z_issue_d;
          if (row_end_d) begin
            // Next row restarts from the stored row bases
            x_q    <= '0;
            y_q    <= y_q + Y_ONE;
            w0_q   <= rb0_q + b01_ext;  rb0_q <= rb0_q + b01_ext;
            w1_q   <= rb1_q + b12_ext;  rb1_q <= rb1_q + b12_ext;
            w2_q   <= rb2_q + b20_ext;  rb2_q <= rb2_q + b20_ext;
            z_q    <= rowz_q + dzdy_q;
            rowz_q <= rowz_q + dzdy_q;
          end else begin
            x_q  <= x_q + X_ONE;
            w0_q <= w0_q + a01_ext;
            w1_q <= w1_q + a12_ext;
            w2_q <= w2_q + a20_ext;
            z_q  <= z_q + dzdx_q;
          end
          if (last_pix_d) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (!v1_q && !v2_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready     = ready_q;
  assign wren      = wren_q;
  assign done      = done_q;
  assign X         = x_out_q;
  assign Y         = y_out_q;
  assign color_out = color_out_q;

endmodule

`default_nettype wire

// File: tb/tb_tile_raster_engine.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_tile_raster_engine                                        |
// | Description : Self-checking bench for tile_raster_engine (32x32 default).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_tile_raster_engine;

  localparam int TWL  = 5;
  localparam int THL  = 5;
  localparam int NPIX = 1 << (TWL + THL);

  typedef struct {
    bit clr;
    int color, zc;
    int w0, w1, w2;
    int a01, a12, a20;
    int b01, b12, b20;
    int dzdx, dzdy;
    int func;
    int exp_wr;
  } job_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              ready, wren, done, clear_in;
  logic [18:0]       A01_in, A12_in, A20_in;
  logic [23:0]       B01_in, B12_in, B20_in;
  logic [31:0]       w0_in, w1_in, w2_in;
  logic [17:0]       dzdx_in, dzdy_in, zC_in;
  logic [15:0]       color_in, color_out;
  logic [1:0]        depth_func;
  logic [TWL-1:0]    X;
  logic [THL-1:0]    Y;
`ifdef TRE_PIXCOUNT_EN
  logic [TWL+THL:0]  pix_count;
`endif

  int errors = 0;
  int checks = 0;
  int mdepth [NPIX];
  job_t jobs [8];

  tile_raster_engine dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .A01_in(A01_in), .A12_in(A12_in), .A20_in(A20_in),
    .B01_in(B01_in), .B12_in(B12_in), .B20_in(B20_in),
    .w0_in(w0_in), .w1_in(w1_in), .w2_in(w2_in),
    .dzdx_in(dzdx_in), .dzdy_in(dzdy_in), .zC_in(zC_in),
    .color_in(color_in), .clear_in(clear_in), .depth_func(depth_func),
    .X(X), .Y(Y), .wren(wren), .color_out(color_out),
`ifdef TRE_PIXCOUNT_EN
    .pix_count(pix_count),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic job_t mk(bit clr, int color, int zc, int w0, int w1, int w2,
                              int a01, int a12, int a20, int b01, int b12, int b20,
                              int dzdx, int dzdy, int func, int exp_wr);
    job_t j;
    j.clr = clr; j.color = color; j.zc = zc;
    j.w0 = w0; j.w1 = w1; j.w2 = w2;
    j.a01 = a01; j.a12 = a12; j.a20 = a20;
    j.b01 = b01; j.b12 = b12; j.b20 = b20;
    j.dzdx = dzdx; j.dzdy = dzdy; j.func = func; j.exp_wr = exp_wr;
    return j;
  endfunction

  // Reference: closed-form edge/Z plane per pixel, depth buffer as an int array
  task automatic model_job(input job_t j, output int q[$]);
    int e0, e1, e2, z, zb;
    bit pass;
    q = {};
    for (int y = 0; y < (1 << THL); y++) begin
      for (int x = 0; x < (1 << TWL); x++) begin
        int idx = y * (1 << TWL) + x;
        if (j.clr) begin
          q.push_back((idx << 16) | j.color);
          mdepth[idx] = j.zc;
        end else begin
          e0 = j.w0 + x * j.a01 + y * j.b01;
          e1 = j.w1 + x * j.a12 + y * j.b12;
          e2 = j.w2 + x * j.a20 + y * j.b20;
          z  = (j.zc + x * j.dzdx + y * j.dzdy) & 32'h3FFFF;
          zb = mdepth[idx];
          case (j.func)
            0:       pass = (z < zb);
            1:       pass = (z <= zb);
            2:       pass = 1'b1;
            default: pass = 1'b0;
          endcase
          if (e0 >= 0 && e1 >= 0 && e2 >= 0 && pass) begin
            q.push_back((idx << 16) | j.color);
            mdepth[idx] = z;
          end
        end
      end
    end
  endtask

  task automatic drive(input job_t j);
    clear_in   = j.clr;
    color_in   = j.color[15:0];
    zC_in      = j.zc[17:0];
    w0_in      = j.w0;  w1_in = j.w1;  w2_in = j.w2;
    A01_in     = j.a01[18:0]; A12_in = j.a12[18:0]; A20_in = j.a20[18:0];
    B01_in     = j.b01[23:0]; B12_in = j.b12[23:0]; B20_in = j.b20[23:0];
    dzdx_in    = j.dzdx[17:0]; dzdy_in = j.dzdy[17:0];
    depth_func = j.func[1:0];
  endtask

  task automatic run_job(input job_t j, input bit hold, input string tag);
    int q[$];
    int nexp, nwr, done_c, pc;
    nwr = 0; done_c = 0; pc = 0;
    model_job(j, q);
    nexp = q.size();
    check({tag, "_ready_before"}, int'(ready), 1);
    @(negedge clk);
    drive(j);
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= NPIX + 40 && done_c == 0; c++) begin
      @(posedge clk); #1;
      if (wren) begin
        nwr++;
        if (q.size() == 0)
          check({tag, "_extra_write"}, (int'({Y, X}) << 16) | int'(color_out), -1);
        else
          check({tag, "_write"}, (int'({Y, X}) << 16) | int'(color_out), q.pop_front());
      end
      if (done) begin
        done_c = c;
        start  = 1'b0;
`ifdef TRE_PIXCOUNT_EN
        pc = int'(pix_count);
`endif
      end
    end
    check({tag, "_done_cycle"}, done_c, NPIX + 3);
    check({tag, "_write_count"}, nwr, nexp);
    if (j.exp_wr >= 0) check({tag, "_table_count"}, nwr, j.exp_wr);
`ifdef TRE_PIXCOUNT_EN
    check({tag, "_pix_count"}, pc, nexp);
`endif
    @(posedge clk); #1;
    check({tag, "_ready_done_after"}, int'({ready, done, wren}), 3'b100);
  endtask

  initial begin
    int bad;
    job_t j;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    //              clr color    zc       w0   w1    w2    a01 a12 a20 b01 b12 b20 dzx dzy fn exp
    jobs[0] = mk(1, 'hF800, 'h3FFFF, 0,   0,    0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 1024);
    jobs[1] = mk(0, 'h07E0, 100,     0,   0,    0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 1024);
    jobs[2] = mk(0, 'h07E0, 100,     0,   0,    0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    jobs[3] = mk(0, 'h07E0, 100,     0,   0,    0,    0, 0, 0, 0, 0, 0, 0, 0, 1, 1024);
    jobs[4] = mk(0, 'h001F, 50,      -16, 1000, 1000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 512);
    jobs[5] = mk(0, 'h5555, 0,       0,   0,    0,    0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
    jobs[6] = mk(1, 'h1234, 0,       0,   0,    0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 1024);
    jobs[7] = mk(0, 'hABCD, 5,       0,   0,    0,    0, 0, 0, 0, 0, 0, 0, 0, 2, 1024);

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(ready), 1);
    check("rst_wren", int'(wren), 0);
    check("rst_done", int'(done), 0);
    check("rst_X", int'(X), 0);
    check("rst_Y", int'(Y), 0);
    check("rst_color", int'(color_out), 0);
`ifdef TRE_PIXCOUNT_EN
    check("rst_pix_count", int'(pix_count), 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_job(jobs[i], 1'b0, $sformatf("vec%0d", i));

    // start held high across WALK and FLUSH must not queue a second job
    run_job(jobs[7], 1'b1, "hold_start");

    // Reset in the middle of a clear job
    @(negedge clk);
    drive(mk(1, 'h0F0F, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_wren", int'(wren), 0);
    check("midrst_ready", int'(ready), 1);
    check("midrst_done", int'(done), 0);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (wren || done || !ready) bad++;
    end
    check("midrst_quiet", bad, 0);

    // Resynchronise the reference depth buffer, then randomised jobs
    run_job(jobs[0], 1'b0, "reclear");
    for (int r = 0; r < 4; r++) begin
      j = mk(0, int'($urandom_range(0, 16'hFFFF)), int'($urandom_range(0, 18'h3FFFF)),
             int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000,
             int'($urandom_range(0, 4000)) - 2000,
             int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)) - 100,
             int'($urandom_range(0, 200)) - 100,
             int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)) - 100,
             int'($urandom_range(0, 200)) - 100,
             int'($urandom_range(0, 18'h3FFFF)), int'($urandom_range(0, 18'h3FFFF)),
             int'($urandom_range(0, 2)), -1);
      run_job(j, 1'b0, $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
